muldiv_unit: RTL and testbench

- Parametrised, multi-cycle multiply/divide unit with HI/LO registers. It replaces single-cycle combinational mul/div in the execute stage.
- Computes signed and unsigned WIDTH×WIDTH multiply and WIDTH/WIDTH divide using a radix-2 iterative datapath, one bit per cycle.
- Uses a start/busy/done handshake. Pipeline stalls while busy; cancel flushes on exception.
- HI/LO are architecturally visible and writable (mthi/mtlo).

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle radix-2 multiply/divide unit with architectural HI/LO.
//   Signed/unsigned WIDTHxWIDTH multiply (shift-add) and WIDTH/WIDTH divide
//   (restoring), one bit per cycle, fixed latency of WIDTH cycles.
// Ports:
//   clk, resetn          clock (rising edge), async active-low reset
//   start, op, src1/2    request, 00 mult / 01 multu / 10 div / 11 divu, operands
//   cancel               abort in-flight operation, also blocks a start in IDLE
//   hi_we, lo_we, wdata  mthi/mtlo writes, honoured only in IDLE
//   busy, done           busy while calculating, done pulses when HI/LO update
//   hi, lo               product high/low or remainder/quotient
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;       // multiplicand magnitude
  logic [WIDTH-1:0] r_b;       // divisor magnitude
  logic [W2-1:0]    r_acc;     // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Operand magnitudes; sign bits are masked to zero for unsigned ops
  logic             w_s1, w_s2;
  logic [WIDTH-1:0] w_abs1, w_abs2;

  assign w_s1   = ~op[0] & src1[WIDTH-1];
  assign w_s2   = ~op[0] & src2[WIDTH-1];
  assign w_abs1 = w_s1 ? -src1 : src1;
  assign w_abs2 = w_s2 ? -src2 : src2;

  // One shift-add multiply step; the extra sum bit carries into the shifted accumulator
  logic [WIDTH:0]  w_mul_sum;
  logic [W2-1:0]   w_mul_nxt;

  assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring divide step: shift in next dividend bit, subtract when it fits
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_sub;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [W2-1:0]    w_div_nxt;

  assign w_rem_sh  = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_sub     = w_rem_sh - {1'b0, r_b};
  assign w_qbit    = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_nxt = WIDTH'(w_qbit ? w_sub : w_rem_sh);
  assign w_div_nxt = {w_rem_nxt, r_acc[WIDTH-2:0], w_qbit};

  logic [W2-1:0] w_acc_nxt;
  assign w_acc_nxt = r_op[1] ? w_div_nxt : w_mul_nxt;

  // Sign correction of the final result
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  always_comb begin
    w_res_hi = w_acc_nxt[W2-1:WIDTH];
    w_res_lo = w_acc_nxt[WIDTH-1:0];
    if (!r_op[1]) begin
      if (r_sign_q) {w_res_hi, w_res_lo} = -w_acc_nxt;
    end else if (r_dz) begin
      w_res_hi = '0;
      w_res_lo = '0;
    end else begin
      if (r_sign_q) w_res_lo = -w_acc_nxt[WIDTH-1:0];
      if (r_sign_r) w_res_hi = -w_acc_nxt[W2-1:WIDTH];
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start && !cancel) begin
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_op     <= op;
            r_a      <= w_abs1;
            r_b      <= w_abs2;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs1 : w_abs2)};
            r_sign_q <= w_s1 ^ w_s2;
            r_sign_r <= w_s1;
            r_dz     <= op[1] & (src2 == '0);
            r_cnt    <= CNT_W'(WIDTH);
          end
        end
        S_CALC: begin
          if (cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_hi    <= w_res_hi;
              r_lo    <= w_res_lo;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32).
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  string       cur_tag  = "none";
  logic [63:0] sb_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .src1(src1), .src2(src2), .cancel(cancel),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference results {hi, lo} from native arithmetic
  function automatic logic [63:0] model(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    int     q, r;
    logic [63:0] up;
    case (f_op)
      2'b00: begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return 64'(p);
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      2'b10: begin
        if (b == 32'd0) return 64'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Completion monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    logic [63:0] e;
    if (resetn && done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check_eq({cur_tag, "_unexpected_done"}, 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq({cur_tag, "_hi"}, 64'(hi), 64'(e[63:32]));
        check_eq({cur_tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      end
    end
  end

  // Drive a start (entered just after a rising edge); returns just after E0
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    @(posedge clk); #1;
    start = 1'b0;
    src1  = $urandom;
    src2  = $urandom;
  endtask

  task automatic start_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
    cur_tag = tag;
    sb_q.push_back(exp);
    issue(o, a, b);
  endtask

  // Wait for done with a bound; checks latency, busy throughout, pulse width
  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    int b = 0;
    while (!done && n < 100) begin
      if (busy) b++;
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      check_eq({tag, "_latency"}, 64'(n), 64'(exp_n));
      check_eq({tag, "_busy_cycles"}, 64'(b), 64'(exp_n));
      check_eq({tag, "_busy_on_done"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    start_op(tag, o, a, b, exp);
    wait_done(tag, 32);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] lo_before;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    int          done_before;

    resetn = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #12;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    #4 resetn = 1'b1;
    @(posedge clk); #1;

    run_op("mult_neg2x3", 2'b00, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op("multu_fffex3", 2'b01, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA});
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_7_0", 2'b11, 32'd7, 32'd0, 64'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
    run_op("div_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 64'd0);

    // start together with cancel in IDLE must not start
    cur_tag = "start_cancel";
    start = 1'b1; cancel = 1'b1; op = 2'b01; src1 = 32'd5; src2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check_eq("start_cancel_busy", 64'(busy), 64'd0);

    // Preload HI/LO, then cancel mid-operation and on the final step
    hi_we = 1'b1; wdata = 32'hAAAA_0000;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_BBBB;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check_eq("preload_hi", 64'(hi), 64'h0000_0000_AAAA_0000);
    check_eq("preload_lo", 64'(lo), 64'h0000_0000_0000_BBBB);

    cur_tag = "cancel10";
    issue(2'b00, 32'h1234_5678, 32'h0000_0077);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check_eq("cancel10_busy", 64'(busy), 64'd0);
    check_eq("cancel10_done", 64'(done), 64'd0);
    check_eq("cancel10_hi", 64'(hi), 64'h0000_0000_AAAA_0000);
    check_eq("cancel10_lo", 64'(lo), 64'h0000_0000_0000_BBBB);

    cur_tag = "cancel_last";
    issue(2'b00, 32'hFFFF_FFFE, 32'd3);
    repeat (31) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check_eq("cancel_last_busy", 64'(busy), 64'd0);
    check_eq("cancel_last_done", 64'(done), 64'd0);
    check_eq("cancel_last_hi", 64'(hi), 64'h0000_0000_AAAA_0000);
    check_eq("cancel_last_lo", 64'(lo), 64'h0000_0000_0000_BBBB);
    run_op("after_cancel", 2'b00, 32'd5, 32'hFFFF_FFFD, {32'hFFFF_FFFF, 32'hFFFF_FFF1});

    // mthi in IDLE
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check_eq("mthi", 64'(hi), 64'h0000_0000_1234_5678);

    // mtlo and start during CALC are ignored
    lo_before   = lo;
    done_before = n_done;
    start_op("divu_busy", 2'b11, 32'd1000, 32'd33, {32'd10, 32'd30});
    repeat (5) @(posedge clk);
    #1;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1; op = 2'b01; src1 = 32'd9; src2 = 32'd9;
    @(posedge clk); #1;
    lo_we = 1'b0; start = 1'b0;
    check_eq("calc_lo_we", 64'(lo), 64'(lo_before));
    check_eq("calc_busy", 64'(busy), 64'd1);
    wait_done("divu_busy", 26);
    repeat (3) @(posedge clk);
    #1;
    check_eq("single_done", 64'(n_done), 64'(done_before + 1));

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'hFFFF_FFFF : ((i == 5) ? 32'd1 : $urandom);
      if (i[0]) rb = rb >> $urandom_range(0, 28);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
    end

    // Async reset mid-CALC clears state between edges
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_1111;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    start_op("reset_mid", 2'b11, 32'hFFFF_FFFF, 32'd3, {32'd0, 32'h5555_5555});
    repeat (10) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check_eq("amid_busy", 64'(busy), 64'd0);
    check_eq("amid_done", 64'(done), 64'd0);
    check_eq("amid_hi", 64'(hi), 64'd0);
    check_eq("amid_lo", 64'(lo), 64'd0);
    sb_q.delete();
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14});

    repeat (2) @(posedge clk);
    #1;
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
